// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage controller and muldiv_unit.
//   start       : request, taken only while busy is low
//   funct3      : op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   op_a, op_b  : rs1 / rs2 values, sampled on accept
//   flush       : abort the in-flight operation
//   busy        : operation in flight
//   done        : one-cycle pulse, result valid from this cycle on
//   result      : registered result, held until the next done
//   div_by_zero : registered with done, set for a divide/remainder by zero
interface muldiv_unit_if #(
    parameter int unsigned XLEN = 32
) ();
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            div_by_zero;

    modport master (
        output start, funct3, op_a, op_b, flush,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, funct3, op_a, op_b, flush,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension unit: one shift-add or restoring-divide step per cycle.
// Fixed latency of XLEN+2 cycles from accept to done, independent of operand values.
//   clk_i   : system clock, rising edge
//   reset_i : synchronous active-high reset
//   bus     : muldiv_unit_if slave port (start/funct3/op_a/op_b/flush in,
//             busy/done/result/div_by_zero out)
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input logic          clk_i,
    input logic          reset_i,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic                sa_q, sa_d;
    logic                sb_q, sb_d;
    logic                bzero_q, bzero_d;
    // Multiplicand magnitude for multiplies, divisor magnitude for divides.
    logic [XLEN-1:0]     opnd_q, opnd_d;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits / quotient bits}.
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;
    logic                dbz_q, dbz_d;

    // Operand decode on the request side.
    logic                a_signed, b_signed;
    logic [XLEN-1:0]     a_mag, b_mag;

    assign a_signed = ~bus.funct3[2] ? (bus.funct3[1:0] != 2'b11) : ~bus.funct3[0];
    assign b_signed = ~bus.funct3[2] ? ~bus.funct3[1] : ~bus.funct3[0];
    // Negating the most-negative value yields 2^(XLEN-1), still correct when read unsigned.
    assign a_mag    = (a_signed & bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
    assign b_mag    = (b_signed & bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

    // Iteration datapath.
    logic [XLEN-1:0]     prod_hi, prod_lo;
    logic [XLEN:0]       mul_sum, div_trial, div_diff;
    logic                div_ge;

    assign prod_hi   = prod_q[2*XLEN-1:XLEN];
    assign prod_lo   = prod_q[XLEN-1:0];
    assign mul_sum   = {1'b0, prod_hi} + (prod_lo[0] ? {1'b0, opnd_q} : '0);
    assign div_trial = {prod_hi, prod_lo[XLEN-1]};
    assign div_diff  = div_trial - {1'b0, opnd_q};
    assign div_ge    = div_trial >= {1'b0, opnd_q};

    // Sign correction and special cases applied in FIX.
    logic [2*XLEN-1:0]   prod_s;
    logic [XLEN-1:0]     quot_s, rem_s, fix_res;

    assign prod_s = (sa_q ^ sb_q) ? -prod_q : prod_q;
    // Divide by zero leaves an all-ones quotient and the dividend magnitude as remainder;
    // the quotient must not be sign-corrected, the remainder sign fix restores op_a.
    // Signed overflow needs no override: |a|/1 = 2^(XLEN-1) with sa^sb = 0 is op_a.
    assign quot_s = bzero_q ? '1 : ((sa_q ^ sb_q) ? -prod_lo : prod_lo);
    assign rem_s  = sa_q ? -prod_hi : prod_hi;

    always_comb begin
        fix_res = prod_s[XLEN-1:0];
        unique case (op_q)
            3'b000:                 fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_res = quot_s;
            3'b110, 3'b111:         fix_res = rem_s;
            default:                fix_res = prod_s[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        bzero_d  = bzero_q;
        opnd_d   = opnd_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // flush wins over a simultaneous start
                if (bus.start && !bus.flush) begin
                    op_d    = bus.funct3;
                    sa_d    = a_signed & bus.op_a[XLEN-1];
                    sb_d    = b_signed & bus.op_b[XLEN-1];
                    bzero_d = (bus.op_b == '0);
                    opnd_d  = bus.funct3[2] ? b_mag : a_mag;
                    prod_d  = {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag : b_mag)};
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (bus.flush) begin
                    state_d = StIdle;
                end else begin
                    if (op_q[2]) begin
                        prod_d = {(div_ge ? div_diff[XLEN-1:0] : div_trial[XLEN-1:0]),
                                  prod_lo[XLEN-2:0], div_ge};
                    end else begin
                        prod_d = {mul_sum, prod_lo[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(XLEN - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                if (!bus.flush) begin
                    result_d = fix_res;
                    dbz_d    = op_q[2] & bzero_q;
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            op_q     <= '0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            bzero_q  <= 1'b0;
            opnd_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            bzero_q  <= bzero_d;
            opnd_q   <= opnd_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    logic clk   = 1'b0;
    logic reset = 1'b1;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for done, check latency, busy length, result and div_by_zero.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input logic exp_dbz);
        int lat   = 0;
        int nbusy = 0;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check_eq({tag, " latency"}, lat, 34);
        check_eq({tag, " busy_cycles"}, nbusy, 33);
        check_eq({tag, " result"}, bus.result, exp_res);
        check_eq({tag, " div_by_zero"}, {31'b0, bus.div_by_zero}, {31'b0, exp_dbz});
    endtask

    task automatic expect_no_done(input string tag, input int cycles);
        int seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        check_eq({tag, " no_done"}, seen, 0);
    endtask

    initial begin
        int t_first;
        int t_second;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.op_a   = '0;
        bus.op_b   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("reset busy", {31'b0, bus.busy}, 0);
        check_eq("reset done", {31'b0, bus.done}, 0);
        check_eq("reset result", bus.result, 0);
        check_eq("reset dbz", {31'b0, bus.div_by_zero}, 0);
        reset = 1'b0;

        run_op("MUL 7*-3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
        run_op("MULH min*min", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0);
        run_op("MULHU max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        run_op("MULHSU -1*2",  3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("DIV -7/2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
        run_op("REM -7/2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
        run_op("DIVU 100/7",   3'b101, 32'd100,      32'd7,        32'd14,       1'b0);
        run_op("REMU 100/7",   3'b111, 32'd100,      32'd7,        32'd2,        1'b0);
        run_op("DIV 5/0",      3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("REM 5/0",      3'b110, 32'd5,        32'd0,        32'd5,        1'b1);
        run_op("DIV -7/0",     3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1);
        run_op("REM -7/0",     3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1);
        run_op("DIV ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
        run_op("REM ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
        run_op("MUL -5*-6",    3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       1'b0);

        // Flush mid-divide: result keeps the MUL value of 30.
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'hFFFFFFF9;
        bus.op_b   = 32'd2;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check_eq("flush busy", {31'b0, bus.busy}, 0);
        expect_no_done("flush", 40);
        check_eq("flush result", bus.result, 32'd30);

        // flush and start together in IDLE: nothing is accepted.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check_eq("idle flush busy", {31'b0, bus.busy}, 0);
        expect_no_done("idle flush", 40);

        // Reset mid-operation after a divide-by-zero left dbz set.
        run_op("DIV 9/0", 3'b100, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1);
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b100;
        bus.op_a   = 32'd100;
        bus.op_b   = 32'd7;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("midreset busy", {31'b0, bus.busy}, 0);
        check_eq("midreset done", {31'b0, bus.done}, 0);
        check_eq("midreset result", bus.result, 0);
        check_eq("midreset dbz", {31'b0, bus.div_by_zero}, 0);
        expect_no_done("midreset", 40);

        // Back-to-back: start held high; operands changed while busy must be ignored.
        t_first  = 0;
        t_second = 0;
        @(posedge clk); #1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op_a   = 32'd3;
        bus.op_b   = 32'd5;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 1 || k == t_first + 1) begin
                bus.op_a = 32'd11;
                bus.op_b = 32'd11;
            end
            if (bus.done) begin
                if (t_first == 0) begin
                    t_first = k;
                    check_eq("b2b first result", bus.result, 32'd15);
                    bus.op_a = 32'd6;
                    bus.op_b = 32'd7;
                end else begin
                    t_second = k;
                    bus.start = 1'b0;
                    check_eq("b2b second result", bus.result, 32'd42);
                    break;
                end
            end
        end
        check_eq("b2b first latency", t_first, 34);
        check_eq("b2b interval", t_second - t_first, 34);
        expect_no_done("b2b tail", 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RISC-V M-extension execution unit, parametrised in operand width.
- Decodes funct3 into the eight MUL/DIV/REM operations and computes the result over multiple cycles: one shift-add or one restoring-divide step per cycle.
- Sits beside the single-cycle ALU in the execute stage.
- The controller stalls the core on `busy` and captures `result` on `done`.

Parameters:
- XLEN, 32, operand/result width in bits (>= 4, even).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when `busy` = 0.
- funct3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  rs1 value; sampled on accept.
- op_b  input  XLEN  rs2 value; sampled on accept.
- flush  input  1  abort the in-flight operation.
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; `result` valid from this cycle on.
- result  output  XLEN  registered result; held until the next `done`.
- div_by_zero  output  1  registered with `done`: 1 if a DIV/DIVU/REM/REMU had `op_b` = 0.

Behaviour:
- Reset (clk edge with reset=1):
  - state = IDLE.
  - busy = 0, done = 0, div_by_zero = 0, result = 0.
  - All internal registers cleared.
  - Applies mid-operation as well; no `done` is produced for the killed operation.
- States: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: `start` = 1 at edge T latches funct3, operand magnitudes and sign flags; counter = 0; next state CALC.
  - CALC: one iteration per cycle, for XLEN cycles (T+1 .. T+XLEN); counter increments; leave CALC when counter = XLEN-1.
  - FIX: one cycle (T+XLEN+1). Applies sign correction and special cases, then writes `result` and `div_by_zero`. `done` = 1 in cycle T+XLEN+2, and state is IDLE then.
- Timing:
  - `busy` = 1 exactly for cycles T+1 .. T+XLEN+1.
  - Fixed latency is XLEN+2 edges from accept to `done`, regardless of operands.
  - A new `start` in the `done` cycle is accepted (back-to-back issue).
  - `start` while busy is ignored; it is not queued.
- flush:
  - In CALC or FIX: return to IDLE next edge; busy = 0; no `done`; `result` keeps its previous value.
  - In IDLE: no effect. `flush` and `start` together in IDLE: flush wins, nothing is accepted.
- Signedness:
  - rs1 is signed for MUL, MULH, MULHSU, DIV and REM.
  - rs2 is signed for MUL, MULH, DIV and REM.
  - All other cases are unsigned.
  - Signed operands are converted to magnitude; sign flags sa and sb are stored.
- Multiply:
  - 2*XLEN-bit shift-add of magnitudes.
  - FIX negates the product if sa^sb.
  - MUL returns the low XLEN bits; MULH, MULHSU and MULHU return the high XLEN bits.
- Divide:
  - Restoring division of magnitudes, producing an XLEN-bit quotient and remainder.
  - FIX: quotient negated if sa^sb; remainder negated if sa (remainder takes the dividend's sign).
- Special cases (override in FIX):
  - `op_b` = 0: quotient = all ones, remainder = `op_a` unchanged, div_by_zero = 1.
  - Signed overflow (`op_a` = most-negative, `op_b` = all ones, DIV/REM): quotient = `op_a`, remainder = 0.
- Arithmetic:
  - All arithmetic is modulo its stated width.
  - Magnitude of most-negative is 2^(XLEN-1), held unsigned; no extra bit is needed.
- `div_by_zero` is 0 for all multiply ops.

Test Plan:
- XLEN=32, MUL: op_a=7, op_b=-3 (0xFFFFFFFD) -> done exactly 34 cycles after accept, result=0xFFFFFFEB; busy high for 33 cycles.
- MULH: 0x80000000 x 0x80000000 -> result=0x40000000. MULHU: 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU: 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; div_by_zero=0 in all four.
- DIV 5/0 -> 0xFFFFFFFF, div_by_zero=1. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Issue DIV, pulse flush at cycle 10 -> no done, busy=0 next cycle, result unchanged. Repeat, asserting reset at cycle 20 -> all outputs 0 next cycle.
- start held high continuously with new operands each done cycle -> done every 34 cycles; second start during busy ignored (operands unchanged in result).
